// File: rtl/half_img_ctrl.sv
// -----------------------------------------------------------------------------
// half_img_ctrl
//
// Purpose:
//   Tracks pixel coordinates in an incoming video stream and flags the right
//   half of each line (col >= HALF_IMG_W) as valid. It checks the line and
//   frame geometry against IMG_W x IMG_H and latches sticky errors when they
//   do not match. Every output is a flop, so all outputs appear exactly one
//   cycle after the inputs that produce them.
//
// Ports:
//   clk          : single clock for all logic
//   rst          : synchronous, active-high reset
//   enable       : run request; when low the controller returns to IDLE and
//                  clears its error flags
//   de_in        : data enable (one active pixel per cycle when high)
//   h_sync_in    : horizontal sync (passed through only)
//   v_sync_in    : vertical sync, high during vertical blanking
//   de_out       : de_in delayed by one cycle
//   h_sync_out   : h_sync_in delayed by one cycle
//   v_sync_out   : v_sync_in delayed by one cycle
//   col_out      : column of the pixel presented on de_out (held when idle)
//   row_out      : row of the pixel presented on de_out (held when idle)
//   valid_out    : pixel on de_out lies in the right half of an ACTIVE line
//   line_start   : strobe on column 0 of every line
//   line_end     : strobe on column IMG_W-1 of every line
//   frame_start  : strobe on pixel (row 0, col 0)
//   frame_done   : strobe on the last pixel of the last line
//   err_line     : sticky; a line was shorter or longer than IMG_W
//   err_frame    : sticky; vsync came early or pixels arrived after the frame
//   state_out    : FSM state (IDLE=0, SYNC=1, ACTIVE=2, DONE=3)
//   frame_cnt    : number of completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module half_img_ctrl #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int HALF_IMG_W = 32,
    parameter int COL_WIDTH  = 11,
    parameter int ROW_WIDTH  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 de_in,
    input  logic                 h_sync_in,
    input  logic                 v_sync_in,
    output logic                 de_out,
    output logic                 h_sync_out,
    output logic                 v_sync_out,
    output logic [COL_WIDTH-1:0] col_out,
    output logic [ROW_WIDTH-1:0] row_out,
    output logic                 valid_out,
    output logic                 line_start,
    output logic                 line_end,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 err_line,
    output logic                 err_frame,
    output logic [1:0]           state_out,
    output logic [15:0]          frame_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [COL_WIDTH-1:0] IMG_W_C    = COL_WIDTH'(IMG_W);
    localparam logic [COL_WIDTH-1:0] LAST_COL_C = COL_WIDTH'(IMG_W - 1);
    localparam logic [COL_WIDTH-1:0] HALF_C     = COL_WIDTH'(HALF_IMG_W);
    localparam logic [ROW_WIDTH-1:0] LAST_ROW_C = ROW_WIDTH'(IMG_H - 1);

    // FSM and line/frame counters
    state_t                 state_q,       state_d;
    logic [COL_WIDTH-1:0]   col_q,         col_d;
    logic [ROW_WIDTH-1:0]   row_q,         row_d;

    // Output registers
    logic                   de_out_q;
    logic                   h_sync_out_q;
    logic                   v_sync_out_q;
    logic [COL_WIDTH-1:0]   col_out_q,     col_out_d;
    logic [ROW_WIDTH-1:0]   row_out_q,     row_out_d;
    logic                   valid_q,       valid_d;
    logic                   line_start_q,  line_start_d;
    logic                   line_end_q,    line_end_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_done_q,  frame_done_d;
    logic                   err_line_q,    err_line_d;
    logic                   err_frame_q,   err_frame_d;
    logic [15:0]            frame_cnt_q,   frame_cnt_d;

    // Edge detectors reuse the delayed sync/enable outputs as the previous
    // sample, so no extra history flops are needed.
    logic                   de_fall_s;
    logic                   vs_fall_s;

    assign de_fall_s = de_out_q & ~de_in;
    assign vs_fall_s = v_sync_out_q & ~v_sync_in;

    // Next-state, counter and output-register computation
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        col_out_d     = col_out_q;
        row_out_d     = row_out_q;
        valid_d       = 1'b0;
        line_start_d  = 1'b0;
        line_end_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        err_line_d    = err_line_q;
        err_frame_d   = err_frame_q;
        frame_cnt_d   = frame_cnt_q;

        if (!enable) begin
            // Dropping enable abandons the frame and clears the sticky errors.
            state_d     = IDLE;
            col_d       = {COL_WIDTH{1'b0}};
            row_d       = {ROW_WIDTH{1'b0}};
            err_line_d  = 1'b0;
            err_frame_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                end

                SYNC: begin
                    // Counters are held at the origin so the frame starts at
                    // (0,0) as soon as vertical blanking ends.
                    col_d = {COL_WIDTH{1'b0}};
                    row_d = {ROW_WIDTH{1'b0}};
                    if (vs_fall_s) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = SYNC;
                    end
                end

                ACTIVE: begin
                    if (de_in) begin
                        col_out_d = col_q;
                        row_out_d = row_q;
                    end else begin
                        col_out_d = col_out_q;
                        row_out_d = row_out_q;
                    end

                    // Error checks come first so that they win over any
                    // normal transition in the same cycle.
                    if (v_sync_in) begin
                        err_frame_d = 1'b1;
                        state_d     = SYNC;
                    end else if (de_in && (col_q >= IMG_W_C)) begin
                        // Pixel IMG_W+1 of an over-long run: reported but
                        // never marked valid.
                        err_line_d = 1'b1;
                        state_d    = SYNC;
                    end else if (de_fall_s && (col_q != IMG_W_C)) begin
                        err_line_d = 1'b1;
                        state_d    = SYNC;
                    end else if (de_in) begin
                        valid_d       = (col_q >= HALF_C);
                        line_start_d  = (col_q == {COL_WIDTH{1'b0}});
                        line_end_d    = (col_q == LAST_COL_C);
                        frame_start_d = (col_q == {COL_WIDTH{1'b0}}) &&
                                        (row_q == {ROW_WIDTH{1'b0}});
                        col_d         = col_q + COL_WIDTH'(1);
                        // The final pixel of the final line closes the frame
                        // immediately so frame_done lines up with it.
                        if ((col_q == LAST_COL_C) && (row_q == LAST_ROW_C)) begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 16'd1;
                            state_d      = DONE;
                        end else begin
                            state_d = ACTIVE;
                        end
                    end else if (de_fall_s) begin
                        col_d   = {COL_WIDTH{1'b0}};
                        row_d   = row_q + ROW_WIDTH'(1);
                        state_d = ACTIVE;
                    end else begin
                        state_d = ACTIVE;
                    end
                end

                DONE: begin
                    if (de_in) begin
                        err_frame_d = 1'b1;
                        state_d     = SYNC;
                    end else if (v_sync_in) begin
                        state_d = SYNC;
                    end else begin
                        state_d = DONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_q         <= {COL_WIDTH{1'b0}};
            row_q         <= {ROW_WIDTH{1'b0}};
            de_out_q      <= 1'b0;
            h_sync_out_q  <= 1'b0;
            v_sync_out_q  <= 1'b1;
            col_out_q     <= {COL_WIDTH{1'b0}};
            row_out_q     <= {ROW_WIDTH{1'b0}};
            valid_q       <= 1'b0;
            line_start_q  <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            de_out_q      <= de_in;
            h_sync_out_q  <= h_sync_in;
            v_sync_out_q  <= v_sync_in;
            col_out_q     <= col_out_d;
            row_out_q     <= row_out_d;
            valid_q       <= valid_d;
            line_start_q  <= line_start_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            err_line_q    <= err_line_d;
            err_frame_q   <= err_frame_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign de_out      = de_out_q;
    assign h_sync_out  = h_sync_out_q;
    assign v_sync_out  = v_sync_out_q;
    assign col_out     = col_out_q;
    assign row_out     = row_out_q;
    assign valid_out   = valid_q;
    assign line_start  = line_start_q;
    assign line_end    = line_end_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign err_line    = err_line_q;
    assign err_frame   = err_frame_q;
    assign state_out   = state_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_half_img_ctrl.sv
// -----------------------------------------------------------------------------
// tb_half_img_ctrl
//
// Drives whole frames into half_img_ctrl. Each driven pixel pushes its
// expected strobes/coordinates onto a scoreboard queue; a monitor pops and
// compares whenever de_out is high. A table of frame scenarios (nominal,
// short line, early vsync, over-long line) is applied in a loop, followed by
// hand-written sequences for mid-frame reset, enable drop and counter wrap.
// -----------------------------------------------------------------------------
module tb_half_img_ctrl;

    localparam int IMG_W = 64;
    localparam int IMG_H = 64;
    localparam int HALF  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        de_in = 1'b0;
    logic        h_sync_in = 1'b0;
    logic        v_sync_in = 1'b0;
    logic        de_out, h_sync_out, v_sync_out;
    logic [10:0] col_out;
    logic [9:0]  row_out;
    logic        valid_out, line_start, line_end, frame_start, frame_done;
    logic        err_line, err_frame;
    logic [1:0]  state_out;
    logic [15:0] frame_cnt;

    half_img_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .HALF_IMG_W(HALF),
        .COL_WIDTH(11), .ROW_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
        .col_out(col_out), .row_out(row_out), .valid_out(valid_out),
        .line_start(line_start), .line_end(line_end),
        .frame_start(frame_start), .frame_done(frame_done),
        .err_line(err_line), .err_frame(err_frame),
        .state_out(state_out), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid, ls, le, fs, fd;
        bit chk;        // compare coordinates too
        int col, row;
    } exp_t;

    typedef struct {
        int n_lines;    // lines driven before the closing vsync
        int bad_line;   // line with non-nominal length (-1: none)
        int bad_len;
        bit exp_el, exp_ef;
        int exp_valid, exp_ls, exp_fd;
        int exp_cnt;    // frame_cnt after one further clean frame
    } rec_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cnt_valid = 0, cnt_ls = 0, cnt_fs = 0, cnt_fd = 0;
    bit   m_act = 1'b0;   // bench's view: is the DUT counting an active frame

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Apply inputs just after a rising edge; return right after the edge that samples them.
    task automatic drive(input bit de, input bit hs, input bit vs);
        de_in     = de;
        h_sync_in = hs;
        v_sync_in = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        cnt_valid = 0; cnt_ls = 0; cnt_fs = 0; cnt_fd = 0;
    endtask

    // One pixel: build expectation from the frame model, push, then drive.
    task automatic pix(input int c, input int row);
        exp_t e;
        e = '{default: 0};
        if (m_act) begin
            e.chk = 1'b1;
            e.col = c;
            e.row = row;
            if (c < IMG_W) begin
                e.valid = (c >= HALF);
                e.ls    = (c == 0);
                e.le    = (c == IMG_W - 1);
                e.fs    = (c == 0) && (row == 0);
                e.fd    = (c == IMG_W - 1) && (row == IMG_H - 1);
            end
            if (c >= IMG_W || e.fd) m_act = 1'b0;
        end
        sb.push_back(e);
        drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_line(input int len, input int row);
        for (int c = 0; c < len; c++) pix(c, row);
        if (len != IMG_W) m_act = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_frame();
        m_act = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        m_act = 1'b1;
    endtask

    task automatic end_frame();
        m_act = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic clean_frame();
        clear_counts();
        start_frame();
        for (int l = 0; l < IMG_H; l++) do_line(IMG_W, l);
        end_frame();
    endtask

    task automatic pulse_reset();
        m_act = 1'b0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (valid_out)   cnt_valid++;
        if (line_start)  cnt_ls++;
        if (frame_start) cnt_fs++;
        if (frame_done)  cnt_fd++;
        if (de_out) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_empty: de_out=1 with no expected pixel queued");
            end else begin
                e = sb.pop_front();
                if (valid_out != e.valid || line_start != e.ls || line_end != e.le ||
                    frame_start != e.fs || frame_done != e.fd ||
                    (e.chk && (int'(col_out) != e.col || int'(row_out) != e.row))) begin
                    failures++;
                    $display("FAIL pixel: actual v=%0b ls=%0b le=%0b fs=%0b fd=%0b col=%0d row=%0d required v=%0b ls=%0b le=%0b fs=%0b fd=%0b col=%0d row=%0d chk=%0b",
                             valid_out, line_start, line_end, frame_start, frame_done,
                             col_out, row_out, e.valid, e.ls, e.le, e.fs, e.fd,
                             e.col, e.row, e.chk);
                end
            end
        end else begin
            checks++;
            if (valid_out || line_start || line_end || frame_start || frame_done) begin
                failures++;
                $display("FAIL idle_strobe: actual v=%0b ls=%0b le=%0b fs=%0b fd=%0b required all 0",
                         valid_out, line_start, line_end, frame_start, frame_done);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t tbl[4];
        tbl[0] = '{64, -1, 64, 1'b0, 1'b0, 2048, 64, 1, 2};
        tbl[1] = '{64,  5, 60, 1'b1, 1'b0,  188,  6, 0, 1};
        tbl[2] = '{40, -1, 64, 1'b0, 1'b1, 1280, 40, 0, 1};
        tbl[3] = '{64, 10, 65, 1'b1, 1'b0,  352, 11, 0, 1};

        // Reset state
        rst = 1'b1;
        enable = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("rst_state",   state_out, 0);
        check("rst_de_out",  de_out, 0);
        check("rst_hs_out",  h_sync_out, 0);
        check("rst_vs_out",  v_sync_out, 1);
        check("rst_frm_cnt", frame_cnt, 0);
        check("rst_errs",    {err_line, err_frame}, 0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        check("idle_to_sync", state_out, 1);

        // Table of frame scenarios
        for (int r = 0; r < 4; r++) begin
            pulse_reset();
            clear_counts();
            start_frame();
            check($sformatf("r%0d_active", r), state_out, 2);
            for (int l = 0; l < tbl[r].n_lines; l++)
                do_line((l == tbl[r].bad_line) ? tbl[r].bad_len : IMG_W, l);
            end_frame();
            check($sformatf("r%0d_err_line", r),  err_line,  tbl[r].exp_el);
            check($sformatf("r%0d_err_frame", r), err_frame, tbl[r].exp_ef);
            check($sformatf("r%0d_state", r),     state_out, 1);
            check($sformatf("r%0d_valid_cnt", r), cnt_valid, tbl[r].exp_valid);
            check($sformatf("r%0d_ls_cnt", r),    cnt_ls,    tbl[r].exp_ls);
            check($sformatf("r%0d_fs_cnt", r),    cnt_fs,    1);
            check($sformatf("r%0d_fd_cnt", r),    cnt_fd,    tbl[r].exp_fd);
            clean_frame();
            check($sformatf("r%0d_next_fd", r),   cnt_fd,    1);
            check($sformatf("r%0d_next_cnt", r),  frame_cnt, tbl[r].exp_cnt);
            check($sformatf("r%0d_sticky", r),    {err_line, err_frame},
                  {tbl[r].exp_el, tbl[r].exp_ef});
        end

        // Reset at row 20 col 10
        start_frame();
        clear_counts();
        for (int l = 0; l < 20; l++) do_line(IMG_W, l);
        for (int c = 0; c < 10; c++) pix(c, 20);
        rst = 1'b1;
        m_act = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        check("mrst_state",   state_out, 0);
        check("mrst_coord",   {col_out, row_out}, 0);
        check("mrst_frm_cnt", frame_cnt, 0);
        check("mrst_outs",    {de_out, h_sync_out, v_sync_out, valid_out}, 4'b0010);
        check("mrst_strobes", {line_start, line_end, frame_start, frame_done}, 0);
        check("mrst_errs",    {err_line, err_frame}, 0);
        rst = 1'b0;
        clear_counts();
        do_line(IMG_W - 11, 20);
        for (int l = 21; l < 24; l++) do_line(IMG_W, l);
        check("mrst_no_valid", cnt_valid, 0);
        check("mrst_no_fd",    cnt_fd, 0);
        check("mrst_sync",     state_out, 1);
        clean_frame();
        check("mrst_next_valid", cnt_valid, 2048);
        check("mrst_next_cnt",   frame_cnt, 1);

        // Enable drop with a sticky error pending
        pulse_reset();
        start_frame();
        for (int l = 0; l < 3; l++) do_line(IMG_W, l);
        drive(1'b0, 1'b0, 1'b1);
        check("en_err_set", err_frame, 1);
        start_frame();
        for (int l = 0; l < 10; l++) do_line(IMG_W, l);
        for (int c = 0; c < 40; c++) pix(c, 10);
        enable = 1'b0;
        m_act = 1'b0;
        pix(40, 10);
        check("en_idle",   state_out, 0);
        check("en_errs",   {err_line, err_frame}, 0);
        check("en_valid",  valid_out, 0);
        enable = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("en_resync", state_out, 1);

        // frame_cnt wrap
        pulse_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        drive(1'b0, 1'b0, 1'b0);
        release dut.frame_cnt_q;
        drive(1'b0, 1'b0, 1'b0);
        check("wrap_preload", frame_cnt, 16'hFFFF);
        clean_frame();
        check("wrap_cnt",  frame_cnt, 0);
        check("wrap_fd",   cnt_fd, 1);
        check("wrap_errs", {err_line, err_frame}, 0);

        drive(1'b0, 1'b0, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/half_img_ctrl.md
HALF_IMG_CTRL -- requirements
Module: half_img_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning active pixels per line.
REQ-002 The block SHALL have parameter IMG_H, default 64, meaning active lines per frame.
REQ-003 The block SHALL have parameter HALF_IMG_W, default 32, meaning left/right split column; legal range 1..IMG_W-1.
REQ-004 The block SHALL have parameters COL_WIDTH, default 11, and ROW_WIDTH, default 10, meaning counter widths.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port enable, input, 1 bit: run request; low forces IDLE.
REQ-008 The block SHALL have inputs de_in, h_sync_in and v_sync_in, 1 bit each: video timing; v_sync_in=1 means vertical blanking.
REQ-009 The block SHALL have outputs de_out, h_sync_out and v_sync_out, 1 bit each: the corresponding inputs delayed by exactly 1 cycle.
REQ-010 The block SHALL have outputs col_out (COL_WIDTH bits) and row_out (ROW_WIDTH bits): coordinates of the pixel on de_out.
REQ-011 The block SHALL have output valid_out, 1 bit: high when de_out=1, col_out>=HALF_IMG_W and state=ACTIVE.
REQ-012 The block SHALL have outputs line_start, line_end, frame_start and frame_done, 1 bit each: single-cycle strobes aligned with de_out.
REQ-013 The block SHALL have outputs err_line and err_frame, 1 bit each: sticky geometry errors.
REQ-014 The block SHALL have outputs state_out (2 bits) and frame_cnt (16 bits): status.

Function
REQ-015 The block SHALL register all outputs, giving a fixed latency of 1 cycle from inputs to outputs.
REQ-016 The FSM SHALL have four states: IDLE=0, SYNC=1, ACTIVE=2, DONE=3.
REQ-017 IDLE SHALL transition to SYNC when enable=1.
REQ-018 In any state, enable=0 SHALL force IDLE on the next cycle.
REQ-019 SYNC SHALL transition to ACTIVE on a v_sync_in falling edge (previous sample 1, current sample 0), with row=0 and col=0.
REQ-020 In ACTIVE, col SHALL increment on each de_in=1 cycle.
REQ-021 In ACTIVE, a de_in falling edge with col==IMG_W SHALL complete the line: col=0, row incremented.
REQ-022 A de_in falling edge with col!=IMG_W SHALL set err_line and transition to SYNC.
REQ-023 Completion of line IMG_H SHALL pulse frame_done on the last pixel, increment frame_cnt and transition to DONE.
REQ-024 DONE SHALL transition to SYNC when v_sync_in=1.
REQ-025 de_in=1 while in DONE SHALL set err_frame and transition to SYNC.
REQ-026 In ACTIVE, v_sync_in=1 before IMG_H lines are complete SHALL set err_frame and transition to SYNC.
REQ-027 A de_in run longer than IMG_W SHALL set err_line on pixel IMG_W+1; that pixel SHALL have valid_out=0, followed by a transition to SYNC.
REQ-028 frame_start SHALL be high on pixel (row 0, col 0).
REQ-029 line_start SHALL be high on col 0 of each line.
REQ-030 line_end SHALL be high on col IMG_W-1 of each line.
REQ-031 Strobes and valid_out SHALL be 0 outside ACTIVE.
REQ-032 col_out and row_out SHALL hold their last values when de_out=0.
REQ-033 frame_cnt SHALL wrap from 0xFFFF to 0 without flagging an error.
REQ-034 When an error and a normal transition occur in the same cycle, the error SHALL take priority.
REQ-035 err_line and err_frame SHALL clear only on rst=1 or enable=0.

Reset
REQ-036 When rst=1, the following SHALL take effect on the next clk edge: state=IDLE; col_out, row_out and frame_cnt=0; all strobes, valid_out, de_out, h_sync_out=0; v_sync_out=1; err flags=0.
REQ-037 Reset mid-frame SHALL abort the frame, with no frame_done emitted.
REQ-038 After reset release, the block SHALL require enable=1 and a fresh v_sync_in falling edge before valid_out can assert.

Verification
REQ-039 The bench SHALL cover a nominal frame: enable=1, 64 lines x 64 de cycles -> 2048 valid_out cycles (cols 32..63 per line), 64 line_start, 1 frame_start, 1 frame_done, frame_cnt=1, no errors.
REQ-040 The bench SHALL cover a short line: line 5 has 60 de cycles -> err_line=1, FSM in SYNC, no frame_done; the next clean frame completes with frame_cnt=1.
REQ-041 The bench SHALL cover early vsync: v_sync_in rises after 40 lines -> err_frame=1, state SYNC, no frame_done.
REQ-042 The bench SHALL cover reset mid-frame: rst=1 at row 20 col 10 -> all outputs at reset values next cycle; valid_out stays 0 until the next v_sync_in falling edge.
REQ-043 The bench SHALL cover enable drop: enable=0 during ACTIVE -> IDLE next cycle, errors cleared, valid_out=0.
REQ-044 The bench SHALL cover counter wrap: preload frame_cnt=0xFFFF by running frames or forcing it -> one more frame gives frame_cnt=0 with no errors.
